mux_scan_collector: RTL and testbench

Sequencer that sits directly in front of the team's 4:1 multiplexer: drives its two address lines, samples its single-bit output, and assembles the four channel values into one 4-bit word. It turns the combinational channel selector into a timed, handshaked scanner: a start pulse (or continuous mode) triggers a full 4-channel sweep, and the word is offered downstream with a valid/ready handshake.

---
 rtl/mux_scan_collector.sv | 112 +++++++++++
 tb/tb_mux_scan_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_collector.sv
// Sequencer in front of a 4:1 mux. It steps the mux select lines, samples the mux
// output after a programmable settle time, and packs the four channel bits into one
// word. The word is offered downstream with a valid/ready handshake.
module mux_scan_collector #(
  parameter int unsigned SETTLE = 1  // cycles each address is held before sampling, 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic       stop,
  output logic       address0,
  output logic       address1,
  input  logic       mux_out,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] word_q, word_d;
  logic       cont_q, cont_d;

  // Next-state logic: scan sequencing, capture and handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    word_d  = word_q;
    // stop drops continuous mode on any edge; a start may re-latch it below.
    cont_d  = cont_q & ~stop;

    unique case (state_q)
      StIdle: begin
        addr_d = 2'd0;
        if (start) begin
          state_d = StScan;
          cnt_d   = 4'd0;
          cap_d   = 4'd0;
          cont_d  = continuous & ~stop;
        end
      end
      StScan: begin
        if (cnt_q == CntLast) begin
          cnt_d         = 4'd0;
          cap_d[addr_q] = mux_out;
          if (addr_q == 2'd3) begin
            word_d  = {mux_out, cap_q[2:0]};
            addr_d  = 2'd0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (word_ready) begin
          // A stop coinciding with the transfer ends the run here.
          if (cont_q && !stop) begin
            state_d = StScan;
            addr_d  = 2'd0;
            cnt_d   = 4'd0;
            cap_d   = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any partial scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 2'd0;
      cnt_q   <= 4'd0;
      cap_q   <= 4'd0;
      word_q  <= 4'd0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      word_q  <= word_d;
      cont_q  <= cont_d;
    end
  end

  // All outputs come straight from registered state: no input-to-output paths.
  always_comb begin
    address0   = addr_q[0];
    address1   = addr_q[1];
    word       = word_q;
    word_valid = (state_q == StDone);
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_mux_scan_collector.sv
// Bench for mux_scan_collector: two instances (SETTLE=1 and SETTLE=3) share stimulus,
// each drives its own model 4:1 mux from a common channel vector. A cycle model based
// on elapsed scan time is compared every cycle; directed literal checks pin the model.
module tb_mux_scan_collector;

  logic       clk = 1'b0;
  logic       reset, start, continuous, stop, word_ready;
  logic [3:0] ch;

  logic       d0_a0, d0_a1, d0_valid, d0_busy, d0_mux;
  logic [3:0] d0_word;
  logic       d1_a0, d1_a1, d1_valid, d1_busy, d1_mux;
  logic [3:0] d1_word;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign d0_mux = ch[{d0_a1, d0_a0}];
  assign d1_mux = ch[{d1_a1, d1_a0}];

  mux_scan_collector #(.SETTLE(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
    .address0(d0_a0), .address1(d0_a1), .mux_out(d0_mux), .word(d0_word),
    .word_valid(d0_valid), .word_ready(word_ready), .busy(d0_busy)
  );

  mux_scan_collector #(.SETTLE(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
    .address0(d1_a0), .address1(d1_a1), .mux_out(d1_mux), .word(d1_word),
    .word_valid(d1_valid), .word_ready(word_ready), .busy(d1_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scanning (t = cycles into the scan), 2 word offered.
  int         m_s[2] = '{1, 3};
  int         m_mode[2];
  int         m_t[2];
  logic [3:0] m_cap[2];
  logic [3:0] m_word[2];
  logic       m_cont[2];

  task automatic model_step(input int i);
    int k;
    if (reset) begin
      m_mode[i] = 0; m_t[i] = 0; m_cap[i] = 4'd0; m_word[i] = 4'd0; m_cont[i] = 1'b0;
    end else if (m_mode[i] == 0) begin
      if (start) begin
        m_mode[i] = 1; m_t[i] = 0; m_cap[i] = 4'd0; m_cont[i] = continuous && !stop;
      end else begin
        m_cont[i] = m_cont[i] && !stop;
      end
    end else if (m_mode[i] == 1) begin
      k = m_t[i] / m_s[i];
      if ((m_t[i] + 1) % m_s[i] == 0) m_cap[i][k] = ch[k];
      if (m_t[i] == 4 * m_s[i] - 1) begin
        m_word[i] = m_cap[i];
        m_mode[i] = 2;
      end else begin
        m_t[i]++;
      end
      m_cont[i] = m_cont[i] && !stop;
    end else begin
      if (word_ready) begin
        if (m_cont[i] && !stop) begin
          m_mode[i] = 1; m_t[i] = 0; m_cap[i] = 4'd0;
        end else begin
          m_mode[i] = 0;
        end
      end
      m_cont[i] = m_cont[i] && !stop;
    end
  endtask

  function automatic int m_addr(input int i);
    return (m_mode[i] == 1) ? m_t[i] / m_s[i] : 0;
  endfunction

  // Per-cycle compare of both instances against the model, 1 time unit after the edge.
  always begin
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("d0_addr",  int'({d0_a1, d0_a0}), m_addr(0));
    chk("d0_word",  int'(d0_word), int'(m_word[0]));
    chk("d0_valid", int'(d0_valid), int'(m_mode[0] == 2));
    chk("d0_busy",  int'(d0_busy), int'(m_mode[0] != 0));
    chk("d1_addr",  int'({d1_a1, d1_a0}), m_addr(1));
    chk("d1_word",  int'(d1_word), int'(m_word[1]));
    chk("d1_valid", int'(d1_valid), int'(m_mode[1] == 2));
    chk("d1_busy",  int'(d1_busy), int'(m_mode[1] != 0));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b1; continuous = 1'b0; stop = 1'b0; word_ready = 1'b1;
    ch = 4'b1101;

    // Reset held two cycles with start high.
    tick(2);
    chk("rst_word", int'(d0_word), 0);
    chk("rst_valid", int'(d0_valid), 0);
    chk("rst_busy", int'(d0_busy), 0);
    chk("rst_addr", int'({d0_a1, d0_a0}), 0);
    chk("rst_busy1", int'(d1_busy), 0);

    // Single scan, start still high at the first edge after release.
    reset = 1'b0;
    tick(1);
    start = 1'b0;
    chk("s1_busy", int'(d0_busy), 1);
    chk("s1_addr0", int'({d0_a1, d0_a0}), 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("s1_addr_seq", int'({d0_a1, d0_a0}), k);
    end
    tick(1);
    chk("s1_valid", int'(d0_valid), 1);
    chk("s1_word", int'(d0_word), 4'b1101);
    chk("s1_addr_done", int'({d0_a1, d0_a0}), 0);
    tick(1);
    chk("s1_valid_fall", int'(d0_valid), 0);
    chk("s1_idle", int'(d0_busy), 0);
    tick(12);

    // Backpressure: ready low, channel 0 flips while waiting, start pulses ignored.
    word_ready = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    chk("bp_valid", int'(d0_valid), 1);
    ch[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      tick(1);
      chk("bp_hold_valid", int'(d0_valid), 1);
      chk("bp_hold_word", int'(d0_word), 4'b1101);
    end
    start = 1'b0;
    word_ready = 1'b1;
    tick(1);
    chk("bp_xfer_valid", int'(d0_valid), 0);
    chk("bp_xfer_busy", int'(d0_busy), 0);
    tick(14);

    // Continuous mode with stop during the second scan.
    ch = 4'b0110;
    continuous = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      stop = (c == 7);
      if (d0_valid) begin
        pulses++;
        chk("cont_word", int'(d0_word), 4'b0110);
        chk("cont_cycle", c, (pulses == 1) ? 4 : 9);
      end
    end
    stop = 1'b0;
    continuous = 1'b0;
    chk("cont_pulses", pulses, 2);
    chk("cont_idle", int'(d0_busy), 0);

    // Reset in the middle of a scan.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("mid_busy", int'(d0_busy), 0);
    chk("mid_word", int'(d0_word), 0);
    chk("mid_addr", int'({d0_a1, d0_a0}), 0);
    chk("mid_word1", int'(d1_word), 0);
    reset = 1'b0;
    tick(2);
    chk("mid_novalid", int'(d0_valid), 0);

    // SETTLE=3 instance: each address held three cycles.
    ch = 4'b1011;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk("s3_addr", int'({d1_a1, d1_a0}), k / 3);
    end
    tick(1);
    chk("s3_valid", int'(d1_valid), 1);
    chk("s3_word", int'(d1_word), 4'b1011);
    chk("s3_addr_done", int'({d1_a1, d1_a0}), 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
